// File: rtl/light_pos_ctrl.sv
// light_pos_ctrl: frame-synchronous controller for the GPU light angles ax/ay.
// Button levels become per-frame step requests with hold-to-repeat. An
// auto-rotate mode advances ax every frame. New angles are committed only on
// vblank_begin, so no frame is shaded with a mix of old and new parameters.
module light_pos_ctrl #(
  parameter int REPEAT_DELAY = 16,
  parameter int REPEAT_RATE  = 4,
  parameter int AUTO_STEP    = 2,
  parameter int AX_INIT      = 29,
  parameter int AY_INIT      = 324
) (
  input  logic        p_reset,
  input  logic        m_clock,
  input  logic        vblank_begin,
  input  logic        btn_x,
  input  logic        btn_y,
  input  logic        btn_mode,
  output logic [8:0]  ax,
  output logic [8:0]  ay,
  output logic        auto_mode,
  output logic        upd,
  output logic [15:0] frame_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_HOLD_DELAY,
    S_HOLD_REPEAT
  } axis_state_t;

  localparam logic [4:0] DELAY_CNT = 5'(REPEAT_DELAY);
  localparam logic [4:0] RATE_CNT  = 5'(REPEAT_RATE);
  localparam logic [9:0] AUTO_INC  = 10'(AUTO_STEP);
  localparam logic [8:0] AX_RST    = 9'(AX_INIT);
  localparam logic [8:0] AY_RST    = 9'(AY_INIT);

  axis_state_t x_state_q, y_state_q;
  logic [4:0]  x_fc_q, y_fc_q;
  logic [4:0]  x_fc_inc, y_fc_inc;
  logic        x_btn_eff;
  logic        x_step, y_step;

  logic        mode_q;
  logic        auto_q;
  logic [8:0]  ax_q, ax_d;
  logic [8:0]  ay_q, ay_d;
  logic        upd_q, upd_d;
  logic [15:0] frame_q, frame_d;

  // Angle addition with a single conditional wrap; 10-bit sum covers 359+359.
  function automatic logic [8:0] wrap_add(input logic [8:0] v, input logic [9:0] s);
    logic [9:0] sum;
    sum = {1'b0, v} + s;
    if (sum >= 10'd360) begin
      sum = sum - 10'd360;
    end
    return sum[8:0];
  endfunction

  // A step is taken on a vblank from ARMED, or when a held counter hits its limit.
  function automatic logic step_req(input axis_state_t st, input logic [4:0] fc_inc,
                                    input logic btn, input logic vb);
    logic req;
    req = 1'b0;
    case (st)
      S_ARMED:       req = vb;
      S_HOLD_DELAY:  req = btn & vb & (fc_inc == DELAY_CNT);
      S_HOLD_REPEAT: req = btn & vb & (fc_inc == RATE_CNT);
      default:       req = 1'b0;
    endcase
    return req;
  endfunction

  // Decode step requests for both axes from the current FSM state.
  always_comb begin
    x_btn_eff = btn_x & ~auto_q;
    x_fc_inc  = x_fc_q + 5'd1;
    y_fc_inc  = y_fc_q + 5'd1;
    x_step    = step_req(x_state_q, x_fc_inc, x_btn_eff, vblank_begin) & ~auto_q;
    y_step    = step_req(y_state_q, y_fc_inc, btn_y, vblank_begin);
  end

  // X axis press/hold/repeat FSM; parked in IDLE while auto mode owns ax.
  always_ff @(posedge m_clock or posedge p_reset) begin
    if (p_reset) begin
      x_state_q <= S_IDLE;
      x_fc_q    <= '0;
    end else if (auto_q) begin
      x_state_q <= S_IDLE;
      x_fc_q    <= '0;
    end else begin
      case (x_state_q)
        S_IDLE: begin
          x_fc_q <= '0;
          if (x_btn_eff) x_state_q <= S_ARMED;
        end
        S_ARMED: begin
          if (vblank_begin) begin
            x_fc_q    <= '0;
            x_state_q <= x_btn_eff ? S_HOLD_DELAY : S_IDLE;
          end
        end
        S_HOLD_DELAY: begin
          if (!x_btn_eff) begin
            x_state_q <= S_IDLE;
            x_fc_q    <= '0;
          end else if (vblank_begin) begin
            if (x_fc_inc == DELAY_CNT) begin
              x_fc_q    <= '0;
              x_state_q <= S_HOLD_REPEAT;
            end else begin
              x_fc_q <= x_fc_inc;
            end
          end
        end
        S_HOLD_REPEAT: begin
          if (!x_btn_eff) begin
            x_state_q <= S_IDLE;
            x_fc_q    <= '0;
          end else if (vblank_begin) begin
            x_fc_q <= (x_fc_inc == RATE_CNT) ? 5'd0 : x_fc_inc;
          end
        end
        default: begin
          x_state_q <= S_IDLE;
          x_fc_q    <= '0;
        end
      endcase
    end
  end

  // Y axis press/hold/repeat FSM; always manual.
  always_ff @(posedge m_clock or posedge p_reset) begin
    if (p_reset) begin
      y_state_q <= S_IDLE;
      y_fc_q    <= '0;
    end else begin
      case (y_state_q)
        S_IDLE: begin
          y_fc_q <= '0;
          if (btn_y) y_state_q <= S_ARMED;
        end
        S_ARMED: begin
          if (vblank_begin) begin
            y_fc_q    <= '0;
            y_state_q <= btn_y ? S_HOLD_DELAY : S_IDLE;
          end
        end
        S_HOLD_DELAY: begin
          if (!btn_y) begin
            y_state_q <= S_IDLE;
            y_fc_q    <= '0;
          end else if (vblank_begin) begin
            if (y_fc_inc == DELAY_CNT) begin
              y_fc_q    <= '0;
              y_state_q <= S_HOLD_REPEAT;
            end else begin
              y_fc_q <= y_fc_inc;
            end
          end
        end
        S_HOLD_REPEAT: begin
          if (!btn_y) begin
            y_state_q <= S_IDLE;
            y_fc_q    <= '0;
          end else if (vblank_begin) begin
            y_fc_q <= (y_fc_inc == RATE_CNT) ? 5'd0 : y_fc_inc;
          end
        end
        default: begin
          y_state_q <= S_IDLE;
          y_fc_q    <= '0;
        end
      endcase
    end
  end

  // Rising edge of btn_mode toggles auto-rotate.
  always_ff @(posedge m_clock or posedge p_reset) begin
    if (p_reset) begin
      mode_q <= 1'b0;
      auto_q <= 1'b0;
    end else begin
      mode_q <= btn_mode;
      if (btn_mode && !mode_q) auto_q <= ~auto_q;
    end
  end

  // Next committed angles, update flag and frame count; only a vblank changes them.
  always_comb begin
    ax_d    = ax_q;
    ay_d    = ay_q;
    frame_d = frame_q;
    if (vblank_begin) begin
      if (auto_q) begin
        ax_d = wrap_add(ax_q, AUTO_INC);
      end else if (x_step) begin
        ax_d = wrap_add(ax_q, 10'd1);
      end
      if (y_step) begin
        ay_d = wrap_add(ay_q, 10'd1);
      end
      frame_d = frame_q + 16'd1;
    end
    upd_d = vblank_begin & ((ax_d != ax_q) | (ay_d != ay_q));
  end

  // Commit registers.
  always_ff @(posedge m_clock or posedge p_reset) begin
    if (p_reset) begin
      ax_q    <= AX_RST;
      ay_q    <= AY_RST;
      upd_q   <= 1'b0;
      frame_q <= '0;
    end else begin
      ax_q    <= ax_d;
      ay_q    <= ay_d;
      upd_q   <= upd_d;
      frame_q <= frame_d;
    end
  end

  assign ax        = ax_q;
  assign ay        = ay_q;
  assign auto_mode = auto_q;
  assign upd       = upd_q;
  assign frame_cnt = frame_q;

endmodule
